sram_copy_engine: RTL and testbench

//   Initiator-side engine for one port of a single-cycle-read dual-port SRAM.

---
 rtl/sram_copy_engine.sv | 114 +++++++++++
 tb/tb_sram_copy_engine.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sram_copy_engine.sv
// Copy/fill engine driving one port of a dual-port SRAM with 1-cycle registered reads.
// Copy alternates RD/WR per word; fill streams one write per cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; command captured on start
// RD    | copy only: present src+i, data returns during the next cycle
// WR    | present dst+i with write enable; data is mem_q (copy) or fill word
// DONE  | one-cycle completion pulse, then back to IDLE
module sram_copy_engine #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [ADDRWIDTH-1:0] src_addr,
  input  logic [ADDRWIDTH-1:0] dst_addr,
  input  logic [ADDRWIDTH:0]   len,
  input  logic [DATAWIDTH-1:0] fill_data,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic                 mem_we,
  output logic [DATAWIDTH-1:0] mem_d,
  input  logic [DATAWIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t               state, state_nx;
  logic [ADDRWIDTH-1:0] cnt;
  logic [ADDRWIDTH-1:0] src_q;
  logic [ADDRWIDTH-1:0] dst_q;
  logic [ADDRWIDTH:0]   len_q;
  logic                 mode_q;
  logic [DATAWIDTH-1:0] fill_q;
  logic                 last;

  // len_q is never 0 outside IDLE/DONE, so len_q-1 cannot underflow where it matters
  assign last = ({1'b0, cnt} == (len_q - 1'b1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      mode_q <= 1'b0;
      fill_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        cnt    <= '0;
        src_q  <= src_addr;
        dst_q  <= dst_addr;
        len_q  <= len;
        mode_q <= mode;
        fill_q <= fill_data;
      end else if (state == WR && !abort && !last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0)   state_nx = DONE;
          else if (mode)   state_nx = WR;
          else             state_nx = RD;
        end
      end
      RD: state_nx = abort ? IDLE : WR;
      WR: begin
        if (abort)       state_nx = IDLE;
        else if (last)   state_nx = DONE;
        else if (mode_q) state_nx = WR;
        else             state_nx = RD;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_d    = '0;
    case (state)
      RD: begin
        busy     = 1'b1;
        mem_addr = src_q + cnt;
      end
      WR: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = dst_q + cnt;
        // read data of the preceding RD arrives in this cycle and is forwarded straight to the write port
        mem_d    = mode_q ? fill_q : mem_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_copy_engine.sv
// Directed bench for sram_copy_engine with a behavioural registered-read SRAM on the engine port.
module tb_sram_copy_engine;

  localparam int DW = 32;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   len;
  logic [DW-1:0] fill_data;
  logic          abort;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  // read-before-write, one-cycle registered read
  always @(posedge clk) begin
    mem_q <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_d;
  end

  sram_copy_engine #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (mem_we === 1'b1) wr_cnt++;
    if (done === 1'b1) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input logic [AW:0] l, input logic [DW-1:0] f);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < (1 << AW); k++) mem[k] = '0;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    len = '0; fill_data = '0; abort = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_d", mem_d, 0);

    // 1: copy 4 words 0x010 -> 0x100
    for (int k = 0; k < 4; k++) mem[16'h010 + k] = k + 1;
    wr_cnt = 0; done_cnt = 0;
    issue(1'b0, 14'h010, 14'h100, 15'd4, '0);
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("copy_we_c%0d", c), mem_we, (c % 2 == 0) && (c <= 8));
      check($sformatf("copy_done_c%0d", c), done, c == 9);
      check($sformatf("copy_busy_c%0d", c), busy, c <= 8);
      if (c <= 8 && c % 2 == 1) check($sformatf("copy_raddr_c%0d", c), mem_addr, 14'h010 + (c - 1) / 2);
      if (c <= 8 && c % 2 == 0) begin
        check($sformatf("copy_waddr_c%0d", c), mem_addr, 14'h100 + (c - 2) / 2);
        check($sformatf("copy_wdata_c%0d", c), mem_d, c / 2);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) check($sformatf("copy_mem_%0d", k), mem[14'h100 + k], k + 1);
    check("copy_wr_cnt", wr_cnt, 4);
    check("copy_done_cnt", done_cnt, 1);

    // 2: fill with address wrap
    mem[1] = 32'h0000_0055;
    issue(1'b1, '0, 14'h3FFE, 15'd3, 32'hDEADBEEF);
    check("fill_addr_c1", mem_addr, 14'h3FFE);
    check("fill_we_c1", mem_we, 1);
    check("fill_d_c1", mem_d, 32'hDEADBEEF);
    tick();
    check("fill_addr_c2", mem_addr, 14'h3FFF);
    tick();
    check("fill_addr_c3", mem_addr, 14'h0000);
    check("fill_we_c3", mem_we, 1);
    tick();
    check("fill_done_c4", done, 1);
    check("fill_we_c4", mem_we, 0);
    tick();
    check("fill_done_c5", done, 0);
    check("fill_mem_3ffe", mem[14'h3FFE], 32'hDEADBEEF);
    check("fill_mem_3fff", mem[14'h3FFF], 32'hDEADBEEF);
    check("fill_mem_0000", mem[0], 32'hDEADBEEF);
    check("fill_mem_0001", mem[1], 32'h0000_0055);

    // 3: zero length
    wr_cnt = 0;
    issue(1'b0, 14'h010, 14'h200, 15'd0, '0);
    check("zero_done_c1", done, 1);
    check("zero_busy_c1", busy, 0);
    check("zero_we_c1", mem_we, 0);
    tick();
    check("zero_done_c2", done, 0);
    check("zero_busy_c2", busy, 0);
    check("zero_wr_cnt", wr_cnt, 0);

    // 4: start while busy is dropped
    wr_cnt = 0; done_cnt = 0;
    issue(1'b1, '0, 14'h200, 15'd8, 32'hA5A5A5A5);
    tick(); tick();
    issue(1'b1, '0, 14'h300, 15'd2, 32'h1111_1111);
    for (int c = 0; c < 12; c++) tick();
    check("busy_wr_cnt", wr_cnt, 8);
    check("busy_done_cnt", done_cnt, 1);
    check("busy_mem_207", mem[14'h207], 32'hA5A5A5A5);
    check("busy_mem_208", mem[14'h208], 0);
    check("busy_mem_300", mem[14'h300], 0);
    check("busy_idle", busy, 0);

    // 5: abort on the 3rd WR of a copy
    for (int k = 0; k < 10; k++) mem[14'h400 + k] = 32'h1000 + k;
    wr_cnt = 0; done_cnt = 0;
    issue(1'b0, 14'h400, 14'h500, 15'd10, '0);
    for (int c = 1; c <= 5; c++) tick();
    check("abort_we_c6", mem_we, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy_c7", busy, 0);
    check("abort_done_c7", done, 0);
    check("abort_wr_cnt", wr_cnt, 3);
    check("abort_mem_502", mem[14'h502], 32'h1002);
    check("abort_mem_503", mem[14'h503], 0);
    issue(1'b1, '0, 14'h600, 15'd1, 32'hCAFE_F00D);
    check("abort_restart_we", mem_we, 1);
    check("abort_restart_addr", mem_addr, 14'h600);
    tick();
    check("abort_restart_done", done, 1);
    check("abort_done_cnt", done_cnt, 0);
    tick();

    // 6: synchronous reset in the cycle of the 4th fill write
    wr_cnt = 0; done_cnt = 0;
    issue(1'b1, '0, 14'h700, 15'd10, 32'h7777_7777);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_busy", busy, 0);
    check("mrst_we", mem_we, 0);
    check("mrst_addr", mem_addr, 0);
    check("mrst_d", mem_d, 0);
    check("mrst_done", done, 0);
    for (int c = 0; c < 12; c++) tick();
    check("mrst_wr_cnt", wr_cnt, 4);
    check("mrst_done_cnt", done_cnt, 0);
    check("mrst_mem_703", mem[14'h703], 32'h7777_7777);
    check("mrst_mem_704", mem[14'h704], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
